joybus_rx: RTL and testbench

JOYBUS_RX -- requirements
Module: joybus_rx

---
 rtl/joybus_rx.sv | 188 ++++++++++++++++++
 tb/tb_joybus_rx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/joybus_rx.sv
// joybus_rx: receiver for a Joybus-style pulse-width-coded serial line.
// Each bit cell is a low phase followed by a high phase. The bit is 1 when
// the high phase is longer than the low phase, and 0 otherwise (ties decode as 0).
// A reception is armed by rx_start. It ends after num_bits cells plus the stop
// cell, or on a line-stuck timeout.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   rx_in      raw open-drain data line (idle high, asynchronous to clk)
//   rx_start   one-cycle pulse arming a reception (aborts any in progress)
//   num_bits   data bits expected, sampled on rx_start
//   rx_busy    high while the receiver is not idle
//   rx_done    one-cycle pulse at the end of a reception
//   rx_err     error flag, valid with rx_done, held until the next rx_start
//   rx_data    received bits, first-received bit at index n-1
//   bits_rcvd  bits shifted in during the current/last reception
module joybus_rx #(
  parameter int unsigned DATA_BITS      = 64,
  parameter int unsigned BIT_CYCLES     = 100,
  parameter int unsigned TIMEOUT_CYCLES = 200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  input  logic                 rx_start,
  input  logic [7:0]           num_bits,
  output logic                 rx_busy,
  output logic                 rx_done,
  output logic                 rx_err,
  output logic [DATA_BITS-1:0] rx_data,
  output logic [7:0]           bits_rcvd
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_LOW   = 3'd1,
    COUNT_LOW  = 3'd2,
    COUNT_HIGH = 3'd3,
    STOP       = 3'd4
  } state_t;

  state_t               state, state_nx;
  logic                 sync1, rx_s;
  logic [CW-1:0]        cnt, cnt_nx;
  logic [CW-1:0]        low_len, low_len_nx;
  logic [7:0]           n_bits, n_bits_nx;
  logic [7:0]           bits_nx;
  logic [DATA_BITS-1:0] data_nx;
  logic                 done_nx, err_nx, busy_nx;
  logic [CW:0]          high_len;
  logic                 bit_val;
  logic [7:0]           n_eff;

  // Two-flop synchronizer; reset to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rx_s  <= sync1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      low_len   <= '0;
      n_bits    <= '0;
      bits_rcvd <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      rx_err    <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      low_len   <= low_len_nx;
      n_bits    <= n_bits_nx;
      bits_rcvd <= bits_nx;
      rx_data   <= data_nx;
      rx_done   <= done_nx;
      rx_err    <= err_nx;
      rx_busy   <= busy_nx;
    end
  end

  // cnt holds low+high samples of the cell, so cnt-low_len is the high length.
  // One extra bit keeps the subtraction from wrapping into the compare.
  always_comb begin
    high_len = {1'b0, cnt} - {1'b0, low_len};
    bit_val  = (high_len > {1'b0, low_len});
    n_eff    = (num_bits > 8'(DATA_BITS)) ? 8'(DATA_BITS) : num_bits;
  end

  // Next-state and output logic.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    low_len_nx = low_len;
    n_bits_nx  = n_bits;
    bits_nx    = bits_rcvd;
    data_nx    = rx_data;
    done_nx    = 1'b0;
    err_nx     = rx_err;

    if (rx_start) begin
      // Arming always wins and silently abandons any reception in progress.
      data_nx   = '0;
      bits_nx   = '0;
      err_nx    = 1'b0;
      n_bits_nx = n_eff;
      cnt_nx    = '0;
      state_nx  = (n_eff == 8'd0) ? STOP : WAIT_LOW;
    end else begin
      case (state)
        IDLE: ;

        WAIT_LOW: begin
          if (!rx_s) begin
            state_nx = COUNT_LOW;
            cnt_nx   = CW'(1);
          end else if (cnt == CW'(TIMEOUT_CYCLES)) begin
            state_nx = IDLE;
            err_nx   = 1'b1;
            done_nx  = 1'b1;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end

        COUNT_LOW: begin
          if (rx_s) begin
            low_len_nx = cnt;
            cnt_nx     = cnt + CW'(1);
            state_nx   = COUNT_HIGH;
          end else if (cnt == CW'(TIMEOUT_CYCLES)) begin
            state_nx = IDLE;
            err_nx   = 1'b1;
            done_nx  = 1'b1;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end

        COUNT_HIGH: begin
          if (!rx_s || (cnt == CW'(BIT_CYCLES))) begin
            data_nx = (rx_data << 1) | DATA_BITS'(bit_val);
            bits_nx = bits_rcvd + 8'd1;
            if (8'(bits_rcvd + 8'd1) == n_bits) begin
              // A falling edge here is the stop cell's low, already one sample in.
              state_nx = STOP;
              cnt_nx   = rx_s ? CW'(0) : CW'(1);
            end else if (!rx_s) begin
              state_nx = COUNT_LOW;
              cnt_nx   = CW'(1);
            end else begin
              state_nx = WAIT_LOW;
              cnt_nx   = '0;
            end
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end

        STOP: begin
          if (rx_s || (cnt == CW'(BIT_CYCLES))) begin
            state_nx = IDLE;
            err_nx   = 1'b0;
            done_nx  = 1'b1;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end

        default: state_nx = IDLE;
      endcase
    end

    busy_nx = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_joybus_rx.sv
// Testbench for joybus_rx: directed frames.
// A cell-level model predicts the completion cycle and the result of each reception.
module tb_joybus_rx;

  localparam int DB      = 64;
  localparam int BC      = 100;
  localparam int TO      = 200;
  localparam int G       = 5;
  localparam int STOP_LO = 50;
  localparam int NEVER   = 32'h7fffffff;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_in;
  logic        rx_start;
  logic [7:0]  num_bits;
  logic        rx_busy;
  logic        rx_done;
  logic        rx_err;
  logic [DB-1:0] rx_data;
  logic [7:0]  bits_rcvd;

  joybus_rx #(.DATA_BITS(DB), .BIT_CYCLES(BC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .rx_start(rx_start),
    .num_bits(num_bits), .rx_busy(rx_busy), .rx_done(rx_done),
    .rx_err(rx_err), .rx_data(rx_data), .bits_rcvd(bits_rcvd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errors  = 0;
  int ndone   = 0;

  // Expected outcome of the reception currently in flight.
  bit          exp_valid = 1'b0;
  int          exp_start = 0;
  int          exp_edge  = NEVER;
  bit          exp_err;
  logic [63:0] exp_data;
  logic [7:0]  exp_bits;
  int          last_s = 0;
  int          last_done_edge = 0;
  int          lo_a[64];
  int          hi_a[64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", 64'(rx_busy), 64'd0);
      chk("rst_done", 64'(rx_done), 64'd0);
      chk("rst_err",  64'(rx_err),  64'd0);
      chk("rst_data", rx_data,      64'd0);
      chk("rst_bits", 64'(bits_rcvd), 64'd0);
    end else begin
      if (rx_done) ndone++;
      if (exp_valid && cyc == exp_edge) begin
        chk("done",      64'(rx_done),   64'd1);
        chk("busy_done", 64'(rx_busy),   64'd0);
        chk("err",       64'(rx_err),    64'(exp_err));
        chk("data",      rx_data,        exp_data);
        chk("bits",      64'(bits_rcvd), 64'(exp_bits));
        last_done_edge = cyc;
        exp_valid = 1'b0;
      end else begin
        chk("done_quiet", 64'(rx_done), 64'd0);
        chk("busy", 64'(rx_busy),
            64'(exp_valid && cyc >= exp_start && cyc < exp_edge));
      end
    end
  end

  task automatic drive(input logic v, input int len);
    rx_in = v;
    repeat (len) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input int nb);
    num_bits = 8'(nb);
    rx_start = 1'b1;
    @(posedge clk);
    #1;
    rx_start = 1'b0;
    last_s   = cyc;
  endtask

  // Mark a reception as started with no end expected yet.
  task automatic plan_open();
    if (!exp_valid) exp_start = cyc + 1;
    exp_valid = 1'b1;
    exp_edge  = NEVER;
  endtask

  task automatic load_pat(input logic [63:0] p, input int k,
                          input int lo1, input int hi1, input int lo0, input int hi0);
    for (int i = 0; i < k; i++) begin
      lo_a[i] = p[k-1-i] ? lo1 : lo0;
      hi_a[i] = p[k-1-i] ? hi1 : hi0;
    end
  endtask

  // Arm, send k cells from lo_a/hi_a, then either a stop cell or a stuck-low line.
  task automatic run_frame(input int nb, input int k, input bit stuck);
    int n;
    int s;
    int a;
    logic [63:0] d;
    n = (nb > DB) ? DB : nb;
    s = cyc + 1;
    d = '0;
    for (int i = 0; i < k; i++) d = (d << 1) | 64'(hi_a[i] > lo_a[i]);
    if (!exp_valid) exp_start = s;
    if (n == 0) begin
      exp_edge = s + 1; exp_err = 1'b0; exp_data = '0; exp_bits = '0;
    end else if (k == 0) begin
      exp_edge = s + TO + 1; exp_err = 1'b1; exp_data = '0; exp_bits = '0;
    end else begin
      // Decisions lag the line by the two synchronizer flops.
      a = s + G + 1;
      for (int i = 0; i < k; i++) a += lo_a[i] + hi_a[i];
      exp_edge = stuck ? (a + 2 + TO) : (a + STOP_LO + 2);
      exp_err  = stuck;
      exp_data = d;
      exp_bits = 8'(k);
    end
    exp_valid = 1'b1;
    pulse_start(nb);
    if (n != 0 && k != 0) begin
      drive(1'b1, G);
      for (int i = 0; i < k; i++) begin
        drive(1'b0, lo_a[i]);
        drive(1'b1, hi_a[i]);
      end
      if (stuck) drive(1'b0, TO + 10);
      else       drive(1'b0, STOP_LO);
      rx_in = 1'b1;
    end
    for (int w = 0; w < 400 && exp_valid; w++) begin
      @(posedge clk);
      #1;
    end
    if (exp_valid) begin
      chk("done_within_bound", 64'd0, 64'd1);
      exp_valid = 1'b0;
    end
    drive(1'b1, 10);
  endtask

  int nd0;
  int s0;

  initial begin
    rx_in    = 1'b1;
    rx_start = 1'b0;
    num_bits = 8'd0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(rx_busy), 64'd0);
    chk("reset_data", rx_data, 64'd0);
    rst_n = 1'b1;
    drive(1'b1, 5);

    // 8 bits 1,0,1,1,0,0,1,0 with 25/75 cells.
    load_pat(64'hB2, 8, 25, 75, 75, 25);
    run_frame(8, 8, 1'b0);
    chk("b2_data", rx_data, 64'h00000000000000B2);
    chk("b2_bits", 64'(bits_rcvd), 64'd8);
    chk("b2_err",  64'(rx_err), 64'd0);

    // 32 bits with skewed 40/60 cells.
    load_pat(64'hDEADBEEF, 32, 40, 60, 60, 40);
    run_frame(32, 32, 1'b0);
    chk("skew_data", rx_data, 64'h00000000DEADBEEF);
    chk("skew_bits", 64'(bits_rcvd), 64'd32);

    // Ties decode as 0; short cells still decode by majority.
    lo_a[0] = 50; hi_a[0] = 50;
    lo_a[1] = 10; hi_a[1] = 30;
    lo_a[2] = 30; hi_a[2] = 10;
    lo_a[3] = 49; hi_a[3] = 51;
    run_frame(4, 4, 1'b0);
    chk("tie_data", rx_data, 64'h5);

    // Line held high: timeout.
    run_frame(8, 0, 1'b0);
    chk("to_latency", 64'(last_done_edge - last_s), 64'd201);
    chk("to_err",  64'(rx_err), 64'd1);
    chk("to_bits", 64'(bits_rcvd), 64'd0);
    drive(1'b1, 10);
    chk("to_err_held", 64'(rx_err), 64'd1);

    // Zero-length reception clears the error.
    run_frame(0, 0, 1'b0);
    chk("zero_latency", 64'(last_done_edge - last_s), 64'd1);
    chk("zero_err", 64'(rx_err), 64'd0);

    // Stuck low after bit 5 of 16.
    load_pat(64'b11010, 5, 25, 75, 75, 25);
    run_frame(16, 5, 1'b1);
    chk("stuck_err",  64'(rx_err), 64'd1);
    chk("stuck_bits", 64'(bits_rcvd), 64'd5);
    chk("stuck_data", rx_data, 64'h1A);

    // Restart during bit 3, then a full frame.
    nd0 = ndone;
    plan_open();
    pulse_start(8);
    drive(1'b1, G);
    drive(1'b0, 25); drive(1'b1, 75);
    drive(1'b0, 75); drive(1'b1, 25);
    drive(1'b0, 25); drive(1'b1, 30);
    load_pat(64'h5C, 8, 25, 75, 75, 25);
    run_frame(8, 8, 1'b0);
    chk("abort_one_done", 64'(ndone - nd0), 64'd1);
    chk("abort_data", rx_data, 64'h5C);

    // Reset mid-frame.
    plan_open();
    pulse_start(16);
    drive(1'b1, G);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 25); drive(1'b1, 75);
    end
    drive(1'b0, 10);
    rst_n = 1'b0;
    exp_valid = 1'b0;
    #1;
    chk("midrst_busy", 64'(rx_busy), 64'd0);
    chk("midrst_data", rx_data, 64'd0);
    chk("midrst_bits", 64'(bits_rcvd), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    nd0 = ndone;
    drive(1'b0, 65);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 75); drive(1'b1, 25);
    end
    drive(1'b0, STOP_LO);
    drive(1'b1, 300);
    chk("postrst_no_done", 64'(ndone - nd0), 64'd0);

    // num_bits above capacity clamps to 64.
    load_pat(64'hA5C30F961234FEDC, 64, 25, 75, 75, 25);
    run_frame(200, 64, 1'b0);
    chk("clamp_data", rx_data, 64'hA5C30F961234FEDC);
    chk("clamp_bits", 64'(bits_rcvd), 64'd64);
    chk("clamp_err",  64'(rx_err), 64'd0);

    drive(1'b1, 5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
